// File: rtl/pwm_ramp_ctrl.sv
// Purpose : soft-start sequencer driving enable/period/dutty of one pwm generator; ramps duty
//           toward a commanded target one step per PWM frame, holds it, and ramps down on stop.
// Latency : all outputs registered; changes appear 1 clk after command acceptance or frame_end.
// Backpr. : cmd_ready high only in IDLE and HOLD (and low in HOLD while stop is asserted).
// Ports   : clk/rst (async active-high); cmd_valid/cmd_ready/cmd_period/cmd_duty/cmd_step
//           command handshake; stop ramp-down request; pwm_enable/pwm_period/pwm_dutty to pwm;
//           busy (RAMP|STOP), done (ramp-down complete pulse), err (rejected command pulse).
module pwm_ramp_ctrl #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_period,
    input  logic [31:0] cmd_duty,
    input  logic [15:0] cmd_step,
    input  logic        stop,
    output logic        pwm_enable,
    output logic [31:0] pwm_period,
    output logic [31:0] pwm_dutty,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

    state_t      state, nxt_state;
    logic [TW-1:0] tick_cnt;
    logic        tick;
    logic [31:0] frame_cnt;
    logic        frame_end;

    logic [31:0] target, nxt_target;
    logic [15:0] step, nxt_step;
    logic [31:0] pend_period, nxt_pend_period;
    logic        pend, nxt_pend;
    logic        nxt_enable, nxt_done, nxt_err;
    logic [31:0] nxt_period, nxt_dutty;

    logic        accept, cmd_ok;
    logic [32:0] sum_up, diff_dn, tgt33;
    logic [31:0] stepped;

    // Free-running microsecond tick.
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Frame counter: one frame is pwm_period+1 ticks, held at 0 while disabled.
    assign frame_end = pwm_enable & tick & (frame_cnt == pwm_period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             frame_cnt <= '0;
        else if (!pwm_enable) frame_cnt <= '0;
        else if (tick)       frame_cnt <= (frame_cnt == pwm_period) ? 32'd0 : frame_cnt + 32'd1;
    end

    // Stop wins over a same-cycle command in HOLD, so ready drops with it.
    assign cmd_ready = (state == IDLE) | ((state == HOLD) & ~stop);
    assign busy      = (state == RAMP) | (state == STOP);
    assign accept    = cmd_valid & cmd_ready;
    assign cmd_ok    = (cmd_period != 32'd0) && (cmd_duty <= cmd_period);

    // One step toward target, computed in 33 bits and clamped so it never overshoots or wraps.
    always_comb begin
        tgt33   = {1'b0, target};
        sum_up  = {1'b0, pwm_dutty} + {17'b0, step};
        diff_dn = {1'b0, pwm_dutty} - {17'b0, step};
        if (pwm_dutty < target)
            stepped = (sum_up >= tgt33) ? target : sum_up[31:0];
        else
            stepped = (diff_dn[32] || (diff_dn < tgt33)) ? target : diff_dn[31:0];
    end

    always_comb begin
        nxt_state       = state;
        nxt_enable      = pwm_enable;
        nxt_period      = pwm_period;
        nxt_dutty       = pwm_dutty;
        nxt_target      = target;
        nxt_step        = step;
        nxt_pend_period = pend_period;
        nxt_pend        = pend;
        nxt_done        = 1'b0;
        nxt_err         = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (!cmd_ok) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_enable = 1'b1;
                        nxt_period = cmd_period;
                        nxt_dutty  = (cmd_step != 16'd0) ? 32'd0 : cmd_duty;
                        nxt_target = cmd_duty;
                        nxt_step   = cmd_step;
                        nxt_pend   = 1'b0;
                        nxt_state  = ((cmd_step != 16'd0) && (cmd_duty != 32'd0)) ? RAMP : HOLD;
                    end
                end
            end

            RAMP: begin
                if (frame_end) begin
                    // A retarget from HOLD spends its first boundary updating the period only.
                    if (pend) begin
                        nxt_period = pend_period;
                        nxt_pend   = 1'b0;
                        if (pwm_dutty == target) nxt_state = HOLD;
                    end else begin
                        nxt_dutty = stepped;
                        if (stepped == target) nxt_state = HOLD;
                    end
                end
            end

            HOLD: begin
                if (frame_end && pend) begin
                    nxt_period = pend_period;
                    nxt_pend   = 1'b0;
                    if (step == 16'd0) nxt_dutty = target;
                end
                if (accept) begin
                    if (!cmd_ok) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_target      = cmd_duty;
                        nxt_step        = cmd_step;
                        nxt_pend_period = cmd_period;
                        nxt_pend        = 1'b1;
                        if (cmd_step != 16'd0) nxt_state = RAMP;
                    end
                end
            end

            STOP: begin
                if (frame_end) begin
                    if (pwm_dutty == 32'd0) begin
                        nxt_enable = 1'b0;
                        nxt_period = 32'd0;
                        nxt_pend   = 1'b0;
                        nxt_done   = 1'b1;
                        nxt_state  = IDLE;
                    end else if (pend) begin
                        nxt_period = pend_period;
                        nxt_pend   = 1'b0;
                    end else begin
                        nxt_dutty = stepped;
                    end
                end
            end

            default: nxt_state = IDLE;
        endcase

        // Stop overrides any transition chosen above; a zero step would never reach 0.
        if (stop && ((state == RAMP) || (state == HOLD))) begin
            nxt_target = 32'd0;
            nxt_state  = STOP;
            if (step == 16'd0) nxt_step = 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pwm_enable  <= 1'b0;
            pwm_period  <= '0;
            pwm_dutty   <= '0;
            target      <= '0;
            step        <= '0;
            pend_period <= '0;
            pend        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= nxt_state;
            pwm_enable  <= nxt_enable;
            pwm_period  <= nxt_period;
            pwm_dutty   <= nxt_dutty;
            target      <= nxt_target;
            step        <= nxt_step;
            pend_period <= nxt_pend_period;
            pend        <= nxt_pend;
            done        <= nxt_done;
            err         <= nxt_err;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_period;
    logic [31:0] cmd_duty;
    logic [15:0] cmd_step;
    logic        stop;
    logic        pwm_enable;
    logic [31:0] pwm_period;
    logic [31:0] pwm_dutty;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [31:0] exp_q[$];

    pwm_ramp_ctrl #(.TICK_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_period (cmd_period),
        .cmd_duty   (cmd_duty),
        .cmd_step   (cmd_step),
        .stop       (stop),
        .pwm_enable (pwm_enable),
        .pwm_period (pwm_period),
        .pwm_dutty  (pwm_dutty),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1)  err_cnt++;
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; stop = 1'b0;
        cmd_period = '0; cmd_duty = '0; cmd_step = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [31:0] p, input logic [31:0] d, input logic [15:0] s,
                            input int max_wait, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_period = p; cmd_duty = d; cmd_step = s;
        for (int i = 0; i < max_wait; i++) begin
            #1;
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_duty(input int max_cyc, output logic [31:0] val, output int cyc, output bit to);
        logic [31:0] prev;
        prev = pwm_dutty;
        val = prev; cyc = 0; to = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (pwm_dutty !== prev) begin
                val = pwm_dutty; cyc = i; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_period(input int max_cyc, output int cyc, output bit to);
        logic [31:0] prev;
        prev = pwm_period;
        cyc = 0; to = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (pwm_period !== prev) begin
                cyc = i; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit to);
        cyc = 0; to = 1'b1;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cyc = i; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; stop = 1'b0;
        cmd_period = '0; cmd_duty = '0; cmd_step = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({pwm_enable, pwm_period, pwm_dutty, busy, done, err} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs got en=%0b per=%0d duty=%0d busy=%0b done=%0b err=%0b need all 0",
                     pwm_enable, pwm_period, pwm_dutty, busy, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got ready=%0b busy=%0b need 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_ramp_stop();
        logic [31:0] v, e;
        int cyc, d0;
        bit to, ok;
        do_reset();
        send_cmd(32'd9, 32'd6, 16'd2, 5, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ramp_accept got not accepted need accepted"); end
        checks++;
        if (pwm_enable !== 1'b1 || pwm_dutty !== 32'd0 || pwm_period !== 32'd9 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ramp_start got en=%0b duty=%0d per=%0d busy=%0b need 1/0/9/1",
                     pwm_enable, pwm_dutty, pwm_period, busy);
        end
        exp_q.push_back(32'd2); exp_q.push_back(32'd4); exp_q.push_back(32'd6);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            wait_duty(100, v, cyc, to);
            checks++;
            if (to || v !== e) begin
                failures++; $display("FAIL ramp_up_duty got %0d (timeout=%0b) need %0d", v, to, e);
            end
            if (i > 0) begin
                checks++;
                if (cyc != 20) begin failures++; $display("FAIL ramp_up_gap got %0d need 20", cyc); end
            end
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL ramp_hold got busy=%0b ready=%0b need 0/1", busy, cmd_ready);
        end
        d0 = done_cnt;
        pulse_stop();
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL stop_enter got busy=%0b ready=%0b need 1/0", busy, cmd_ready);
        end
        exp_q.push_back(32'd4); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            wait_duty(100, v, cyc, to);
            checks++;
            if (to || v !== e) begin
                failures++; $display("FAIL ramp_down_duty got %0d (timeout=%0b) need %0d", v, to, e);
            end
            if (i > 0) begin
                checks++;
                if (cyc != 20) begin failures++; $display("FAIL ramp_down_gap got %0d need 20", cyc); end
            end
        end
        wait_done(100, cyc, to);
        checks++;
        if (to || cyc != 20) begin
            failures++; $display("FAIL stop_done got cyc=%0d timeout=%0b need 20", cyc, to);
        end
        checks++;
        if (pwm_enable !== 1'b0 || pwm_period !== 32'd0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stop_idle got en=%0b per=%0d ready=%0b busy=%0b need 0/0/1/0",
                     pwm_enable, pwm_period, cmd_ready, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++; $display("FAIL stop_done_count got %0d need 1", done_cnt - d0);
        end
    endtask

    task automatic test_invalid();
        int e0;
        bit ok;
        do_reset();
        e0 = err_cnt;
        send_cmd(32'd10, 32'd12, 16'd1, 5, ok);
        checks++;
        if (!ok || err !== 1'b1) begin
            failures++; $display("FAIL invalid_duty_err got ok=%0b err=%0b need 1/1", ok, err);
        end
        send_cmd(32'd0, 32'd0, 16'd1, 5, ok);
        checks++;
        if (!ok || err !== 1'b1) begin
            failures++; $display("FAIL invalid_period_err got ok=%0b err=%0b need 1/1", ok, err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt - e0 != 2) begin
            failures++; $display("FAIL invalid_err_count got %0d need 2", err_cnt - e0);
        end
        checks++;
        if (pwm_enable !== 1'b0 || pwm_period !== 32'd0 || pwm_dutty !== 32'd0 ||
            busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL invalid_state got en=%0b per=%0d duty=%0d busy=%0b ready=%0b need 0/0/0/0/1",
                     pwm_enable, pwm_period, pwm_dutty, busy, cmd_ready);
        end
    endtask

    task automatic test_step0();
        logic [31:0] v, e;
        int cyc;
        bit to, ok;
        do_reset();
        send_cmd(32'd50, 32'd25, 16'd0, 5, ok);
        checks++;
        if (!ok || pwm_dutty !== 32'd25 || pwm_enable !== 1'b1 || pwm_period !== 32'd50 ||
            busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL step0_jump got ok=%0b duty=%0d en=%0b per=%0d busy=%0b ready=%0b need 1/25/1/50/0/1",
                     ok, pwm_dutty, pwm_enable, pwm_period, busy, cmd_ready);
        end
        pulse_stop();
        for (int k = 24; k >= 0; k--) exp_q.push_back(32'(k));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            wait_duty(150, v, cyc, to);
            checks++;
            if (to || v !== e) begin
                failures++; $display("FAIL step0_down_duty got %0d (timeout=%0b) need %0d", v, to, e);
            end
            if (i > 0) begin
                checks++;
                if (cyc != 102) begin failures++; $display("FAIL step0_down_gap got %0d need 102", cyc); end
            end
        end
        wait_done(150, cyc, to);
        checks++;
        if (to || pwm_enable !== 1'b0) begin
            failures++; $display("FAIL step0_done got timeout=%0b en=%0b need 0/0", to, pwm_enable);
        end
    endtask

    task automatic test_retarget();
        logic [31:0] v, e;
        int cyc;
        bit to, ok;
        do_reset();
        send_cmd(32'd9, 32'd6, 16'd2, 5, ok);
        for (int i = 0; i < 3; i++) wait_duty(100, v, cyc, to);
        checks++;
        if (to || pwm_dutty !== 32'd6 || busy !== 1'b0) begin
            failures++; $display("FAIL retarget_setup got duty=%0d busy=%0b need 6/0", pwm_dutty, busy);
        end
        send_cmd(32'd19, 32'd1, 16'd4, 5, ok);
        checks++;
        if (!ok || busy !== 1'b1 || pwm_period !== 32'd9) begin
            failures++;
            $display("FAIL retarget_accept got ok=%0b busy=%0b per=%0d need 1/1/9", ok, busy, pwm_period);
        end
        wait_period(40, cyc, to);
        checks++;
        if (to || pwm_period !== 32'd19 || pwm_dutty !== 32'd6) begin
            failures++;
            $display("FAIL retarget_period got per=%0d duty=%0d timeout=%0b need 19/6", pwm_period, pwm_dutty, to);
        end
        exp_q.push_back(32'd2); exp_q.push_back(32'd1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_duty(100, v, cyc, to);
            checks++;
            if (to || v !== e || cyc != 40) begin
                failures++;
                $display("FAIL retarget_duty got %0d after %0d (timeout=%0b) need %0d after 40", v, cyc, to, e);
            end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL retarget_hold got busy=%0b need 0", busy); end
    endtask

    task automatic test_collision();
        logic [31:0] v, e;
        int cyc, bad, e0;
        bit to, ok, reached;
        do_reset();
        send_cmd(32'd9, 32'd4, 16'd2, 5, ok);
        cmd_valid = 1'b1; cmd_period = 32'd9; cmd_duty = 32'd8; cmd_step = 16'd4;
        bad = 0; reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (busy === 1'b0) begin reached = 1'b1; break; end
            if (cmd_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (!reached || bad != 0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL busy_ready got hold=%0b ready_while_busy=%0d ready=%0b need 1/0/1", reached, bad, cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL held_cmd_accept got busy=%0b need 1", busy); end
        wait_duty(100, v, cyc, to);
        checks++;
        if (to || v !== 32'd8 || busy !== 1'b0) begin
            failures++; $display("FAIL held_cmd_ramp got duty=%0d busy=%0b need 8/0", v, busy);
        end
        e0 = err_cnt;
        @(negedge clk);
        stop = 1'b1;
        cmd_valid = 1'b1; cmd_period = 32'd9; cmd_duty = 32'd2; cmd_step = 16'd0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL collision_ready got %0b need 0", cmd_ready); end
        @(negedge clk);
        stop = 1'b0; cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || pwm_dutty !== 32'd8) begin
            failures++; $display("FAIL collision_stop got busy=%0b duty=%0d need 1/8", busy, pwm_dutty);
        end
        exp_q.push_back(32'd4); exp_q.push_back(32'd0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_duty(100, v, cyc, to);
            checks++;
            if (to || v !== e) begin
                failures++; $display("FAIL collision_down got %0d (timeout=%0b) need %0d", v, to, e);
            end
        end
        wait_done(100, cyc, to);
        checks++;
        if (to || err_cnt != e0) begin
            failures++; $display("FAIL collision_done got timeout=%0b errs=%0d need 0/0", to, err_cnt - e0);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        int cyc;
        bit to, ok;
        do_reset();
        send_cmd(32'd9, 32'd6, 16'd2, 5, ok);
        for (int i = 0; i < 2; i++) wait_duty(100, v, cyc, to);
        checks++;
        if (to || pwm_dutty !== 32'd4 || busy !== 1'b1) begin
            failures++; $display("FAIL areset_setup got duty=%0d busy=%0b need 4/1", pwm_dutty, busy);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pwm_enable, pwm_period, pwm_dutty, busy, done, err} !== 67'd0) begin
            failures++;
            $display("FAIL areset_outputs got en=%0b per=%0d duty=%0d busy=%0b done=%0b err=%0b need all 0",
                     pwm_enable, pwm_period, pwm_dutty, busy, done, err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || pwm_enable !== 1'b0) begin
            failures++; $display("FAIL areset_release got ready=%0b en=%0b need 1/0", cmd_ready, pwm_enable);
        end
        send_cmd(32'd9, 32'd2, 16'd2, 5, ok);
        checks++;
        if (!ok || pwm_enable !== 1'b1 || pwm_dutty !== 32'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL areset_restart got ok=%0b en=%0b duty=%0d busy=%0b need 1/1/0/1", ok, pwm_enable, pwm_dutty, busy);
        end
        wait_duty(100, v, cyc, to);
        checks++;
        if (to || v !== 32'd2 || busy !== 1'b0) begin
            failures++; $display("FAIL areset_ramp got duty=%0d busy=%0b need 2/0", v, busy);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_stop();
        test_invalid();
        test_step0();
        test_retarget();
        test_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
